// File: rtl/avg_pkg.sv
// Shared types and helpers for the boxcar averaging filter.
package avg_pkg;

    typedef enum logic {
        FILLING = 1'b0,
        RUNNING = 1'b1
    } avg_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if (value > (1 << i)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Half an LSB of the shifted result, added before the divide when rounding.
    function automatic int round_offset(input int log2_depth, input int round_en);
        return (round_en != 0) ? (1 << (log2_depth - 1)) : 0;
    endfunction

endpackage

// File: rtl/avg_sample_ram.sv
// Sample window storage: one write port, one asynchronous read port, no reset.
module avg_sample_ram
    import avg_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read is combinational so the caller sees the entry about to be overwritten.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/moving_average_filter.sv
// Boxcar average of the last 2**LOG2_DEPTH accepted samples using a running sum.
//
//   state   | meaning
//   FILLING | fewer than DEPTH samples held since reset/clear, oldest sample not subtracted
//   RUNNING | window full, each accept replaces the oldest sample, FULL asserted
module moving_average_filter
    import avg_pkg::*;
#(
    parameter int DATA_W     = 14,
    parameter int LOG2_DEPTH = 3,
    parameter int ROUND      = 0,
    parameter int WARMUP     = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CLEAR,
    input  logic              IN_VALID,
    input  logic [DATA_W-1:0] DATA_IN,
    output logic [DATA_W-1:0] AVG_OUT,
    output logic              OUT_VALID,
    output logic              FULL
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = DATA_W + LOG2_DEPTH;
    localparam logic [SUM_W:0]      RND_OFF   = (SUM_W + 1)'(round_offset(LOG2_DEPTH, ROUND));
    localparam logic [LOG2_DEPTH:0] FILL_LAST = (LOG2_DEPTH + 1)'(DEPTH - 1);

    avg_state_e              state;
    avg_state_e              state_next;
    logic [LOG2_DEPTH-1:0]   wr_ptr;
    logic [LOG2_DEPTH:0]     fill;
    logic [SUM_W-1:0]        sum;
    logic [SUM_W-1:0]        sum_next;
    logic [SUM_W:0]          avg_rounded;
    logic [DATA_W-1:0]       avg_next;
    logic [DATA_W-1:0]       old_sample;
    logic                    accept;
    logic                    last_fill;
    logic                    full_c;
    logic                    out_load;

    assign accept    = IN_VALID && !CLEAR;
    assign last_fill = (fill == FILL_LAST);

    avg_sample_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .CLK     (CLK),
        .wr_en   (accept),
        .wr_addr (wr_ptr),
        .wr_data (DATA_IN),
        .rd_addr (wr_ptr),
        .rd_data (old_sample)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= FILLING;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (CLEAR) begin
            state_next = FILLING;
        end else if (accept && (state == FILLING) && last_fill) begin
            state_next = RUNNING;
        end
    end

    always_comb begin
        full_c   = (state == RUNNING);
        out_load = 1'b0;
        if (accept) begin
            out_load = (WARMUP == 0) || full_c || last_fill;
        end
    end

    // Memory contents are only subtracted once the window is full, so stale RAM never leaks in.
    assign sum_next    = sum + SUM_W'(DATA_IN) - (full_c ? SUM_W'(old_sample) : '0);
    assign avg_rounded = {1'b0, sum_next} + RND_OFF;
    assign avg_next    = DATA_W'(avg_rounded >> LOG2_DEPTH);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr    <= '0;
            fill      <= '0;
            sum       <= '0;
            AVG_OUT   <= '0;
            OUT_VALID <= 1'b0;
        end else if (CLEAR) begin
            wr_ptr    <= '0;
            fill      <= '0;
            sum       <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            OUT_VALID <= out_load;
            if (accept) begin
                wr_ptr <= wr_ptr + LOG2_DEPTH'(1);
                sum    <= sum_next;
                if (!full_c) begin
                    fill <= fill + (LOG2_DEPTH + 1)'(1);
                end
            end
            if (out_load) begin
                AVG_OUT <= avg_next;
            end
        end
    end

    assign FULL = full_c;

endmodule

// File: tb/tb_moving_average_filter.sv
// Directed bench for moving_average_filter: three instances share stimulus (truncate, round, no warm-up).
module tb_moving_average_filter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        CLEAR;
    logic        IN_VALID;
    logic [13:0] DATA_IN;

    logic [13:0] avg_t, avg_r, avg_n;
    logic        vld_t, vld_r, vld_n;
    logic        full_t, full_r, full_n;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    moving_average_filter #(.DATA_W(14), .LOG2_DEPTH(3), .ROUND(0), .WARMUP(1)) u_trunc (
        .CLK(CLK), .RST_N(RST_N), .CLEAR(CLEAR), .IN_VALID(IN_VALID), .DATA_IN(DATA_IN),
        .AVG_OUT(avg_t), .OUT_VALID(vld_t), .FULL(full_t));

    moving_average_filter #(.DATA_W(14), .LOG2_DEPTH(3), .ROUND(1), .WARMUP(1)) u_round (
        .CLK(CLK), .RST_N(RST_N), .CLEAR(CLEAR), .IN_VALID(IN_VALID), .DATA_IN(DATA_IN),
        .AVG_OUT(avg_r), .OUT_VALID(vld_r), .FULL(full_r));

    moving_average_filter #(.DATA_W(14), .LOG2_DEPTH(3), .ROUND(0), .WARMUP(0)) u_nowarm (
        .CLK(CLK), .RST_N(RST_N), .CLEAR(CLEAR), .IN_VALID(IN_VALID), .DATA_IN(DATA_IN),
        .AVG_OUT(avg_n), .OUT_VALID(vld_n), .FULL(full_n));

    task automatic push(input int v);
        IN_VALID = 1'b1;
        DATA_IN  = 14'(v);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic clear_cycle();
        CLEAR = 1'b1;
        @(posedge CLK);
        #1;
        CLEAR = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; CLEAR = 1'b0; IN_VALID = 1'b0; DATA_IN = '0;
        #12;
        checks++; if (avg_t !== 14'd0) begin errors++; $display("FAIL reset_avg_t: got %0d want 0", avg_t); end
        checks++; if (vld_t !== 1'b0) begin errors++; $display("FAIL reset_vld_t: got %b want 0", vld_t); end
        checks++; if (full_t !== 1'b0) begin errors++; $display("FAIL reset_full_t: got %b want 0", full_t); end
        checks++; if (avg_n !== 14'd0) begin errors++; $display("FAIL reset_avg_n: got %0d want 0", avg_n); end
        checks++; if (full_r !== 1'b0) begin errors++; $display("FAIL reset_full_r: got %b want 0", full_r); end
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_warmup();
        for (int k = 1; k <= 8; k++) begin
            push(100);
            checks++; if (vld_t !== (k == 8)) begin errors++; $display("FAIL warmup_vld_t k=%0d: got %b want %b", k, vld_t, (k == 8)); end
            checks++; if (full_t !== (k == 8)) begin errors++; $display("FAIL warmup_full_t k=%0d: got %b want %b", k, full_t, (k == 8)); end
            checks++; if (avg_t !== 14'((k == 8) ? 100 : 0)) begin errors++; $display("FAIL warmup_avg_t k=%0d: got %0d want %0d", k, avg_t, (k == 8) ? 100 : 0); end
            checks++; if (vld_n !== 1'b1) begin errors++; $display("FAIL warmup_vld_n k=%0d: got %b want 1", k, vld_n); end
            checks++; if (avg_n !== 14'((100 * k) / 8)) begin errors++; $display("FAIL warmup_avg_n k=%0d: got %0d want %0d", k, avg_n, (100 * k) / 8); end
        end
        checks++; if (avg_r !== 14'd100) begin errors++; $display("FAIL warmup_avg_r: got %0d want 100", avg_r); end
    endtask

    task automatic test_step();
        for (int j = 1; j <= 8; j++) begin
            push(900);
            checks++; if (vld_t !== 1'b1) begin errors++; $display("FAIL step_vld_t j=%0d: got %b want 1", j, vld_t); end
            checks++; if (avg_t !== 14'(100 + 100 * j)) begin errors++; $display("FAIL step_avg_t j=%0d: got %0d want %0d", j, avg_t, 100 + 100 * j); end
        end
    endtask

    task automatic test_gap();
        for (int g = 0; g < 3; g++) begin
            @(posedge CLK);
            #1;
            checks++; if (vld_t !== 1'b0) begin errors++; $display("FAIL gap_vld_t g=%0d: got %b want 0", g, vld_t); end
            checks++; if (vld_n !== 1'b0) begin errors++; $display("FAIL gap_vld_n g=%0d: got %b want 0", g, vld_n); end
            checks++; if (avg_t !== 14'd900) begin errors++; $display("FAIL gap_avg_t g=%0d: got %0d want 900", g, avg_t); end
            checks++; if (full_t !== 1'b1) begin errors++; $display("FAIL gap_full_t g=%0d: got %b want 1", g, full_t); end
        end
    endtask

    task automatic test_round();
        clear_cycle();
        checks++; if (full_t !== 1'b0) begin errors++; $display("FAIL round_clr_full: got %b want 0", full_t); end
        checks++; if (avg_t !== 14'd900) begin errors++; $display("FAIL round_clr_hold: got %0d want 900", avg_t); end
        for (int k = 1; k <= 8; k++) begin
            push((k == 8) ? 4 : 0);
            checks++; if (vld_r !== (k == 8)) begin errors++; $display("FAIL round_vld_r k=%0d: got %b want %b", k, vld_r, (k == 8)); end
        end
        checks++; if (avg_r !== 14'd1) begin errors++; $display("FAIL round_half_up: got %0d want 1", avg_r); end
        checks++; if (avg_t !== 14'd0) begin errors++; $display("FAIL round_trunc: got %0d want 0", avg_t); end
        checks++; if (avg_n !== 14'd0) begin errors++; $display("FAIL round_nowarm: got %0d want 0", avg_n); end
        checks++; if (full_r !== 1'b1) begin errors++; $display("FAIL round_full_r: got %b want 1", full_r); end
    endtask

    task automatic test_nowarm();
        clear_cycle();
        push(800);
        checks++; if (avg_n !== 14'd100) begin errors++; $display("FAIL nowarm_first: got %0d want 100", avg_n); end
        checks++; if (vld_n !== 1'b1) begin errors++; $display("FAIL nowarm_first_vld: got %b want 1", vld_n); end
        checks++; if (vld_t !== 1'b0) begin errors++; $display("FAIL nowarm_trunc_vld: got %b want 0", vld_t); end
        for (int k = 1; k <= 16; k++) begin
            push(16383);
            if (k == 7) begin
                checks++; if (avg_t !== 14'd14435) begin errors++; $display("FAIL mixed_avg_t: got %0d want 14435", avg_t); end
                checks++; if (avg_r !== 14'd14435) begin errors++; $display("FAIL mixed_avg_r: got %0d want 14435", avg_r); end
                checks++; if (vld_t !== 1'b1) begin errors++; $display("FAIL mixed_vld_t: got %b want 1", vld_t); end
            end
            if (k == 8) begin
                checks++; if (avg_n !== 14'd16383) begin errors++; $display("FAIL evict_800: got %0d want 16383", avg_n); end
            end
        end
        checks++; if (avg_n !== 14'd16383) begin errors++; $display("FAIL max_avg_n: got %0d want 16383", avg_n); end
        checks++; if (avg_t !== 14'd16383) begin errors++; $display("FAIL max_avg_t: got %0d want 16383", avg_t); end
        checks++; if (avg_r !== 14'd16383) begin errors++; $display("FAIL max_avg_r: got %0d want 16383", avg_r); end
    endtask

    task automatic test_clear_with_valid();
        CLEAR = 1'b1; IN_VALID = 1'b1; DATA_IN = 14'd5000;
        @(posedge CLK);
        #1;
        CLEAR = 1'b0; IN_VALID = 1'b0;
        checks++; if (full_t !== 1'b0) begin errors++; $display("FAIL clrv_full: got %b want 0", full_t); end
        checks++; if (vld_t !== 1'b0) begin errors++; $display("FAIL clrv_vld_t: got %b want 0", vld_t); end
        checks++; if (vld_n !== 1'b0) begin errors++; $display("FAIL clrv_vld_n: got %b want 0", vld_n); end
        checks++; if (avg_t !== 14'd16383) begin errors++; $display("FAIL clrv_hold: got %0d want 16383", avg_t); end
        for (int k = 1; k <= 8; k++) begin
            push(50);
            checks++; if (avg_n !== 14'((50 * k) / 8)) begin errors++; $display("FAIL clrv_avg_n k=%0d: got %0d want %0d", k, avg_n, (50 * k) / 8); end
            checks++; if (vld_t !== (k == 8)) begin errors++; $display("FAIL clrv_vld_t k=%0d: got %b want %b", k, vld_t, (k == 8)); end
        end
        checks++; if (avg_t !== 14'd50) begin errors++; $display("FAIL clrv_avg_t: got %0d want 50", avg_t); end
        checks++; if (full_t !== 1'b1) begin errors++; $display("FAIL clrv_full_after: got %b want 1", full_t); end
    endtask

    task automatic test_back_to_back();
        push(130);
        checks++; if (avg_t !== 14'd60) begin errors++; $display("FAIL b2b_first: got %0d want 60", avg_t); end
        push(130);
        checks++; if (avg_t !== 14'd70) begin errors++; $display("FAIL b2b_second: got %0d want 70", avg_t); end
    endtask

    task automatic test_async_reset();
        push(200);
        #2;
        RST_N = 1'b0;
        #1;
        checks++; if (avg_t !== 14'd0) begin errors++; $display("FAIL arst_avg_t: got %0d want 0", avg_t); end
        checks++; if (vld_t !== 1'b0) begin errors++; $display("FAIL arst_vld_t: got %b want 0", vld_t); end
        checks++; if (full_t !== 1'b0) begin errors++; $display("FAIL arst_full_t: got %b want 0", full_t); end
        checks++; if (avg_n !== 14'd0) begin errors++; $display("FAIL arst_avg_n: got %0d want 0", avg_n); end
        @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            push(200);
            checks++; if (avg_n !== 14'(25 * k)) begin errors++; $display("FAIL arst_avg_n k=%0d: got %0d want %0d", k, avg_n, 25 * k); end
            checks++; if (vld_t !== (k == 8)) begin errors++; $display("FAIL arst_vld_t k=%0d: got %b want %b", k, vld_t, (k == 8)); end
        end
        checks++; if (avg_t !== 14'd200) begin errors++; $display("FAIL arst_refill: got %0d want 200", avg_t); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_warmup();
        test_step();
        test_gap();
        test_round();
        test_nowarm();
        test_clear_with_valid();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
